res_reader: RTL

RES_READER -- requirements
Module: res_reader

---
 rtl/res_reader_pkg.sv | 12 +
 rtl/res_rd_fifo.sv | 47 ++++
 rtl/res_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/res_reader_pkg.sv
// res_reader_pkg: shared constants and types for the result-memory reader.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF / TOTAL_ADDR_DEF : default result memory geometry
//   FIFO_DEPTH : output buffer depth, which is also the issue credit limit
//   state_t    : readout FSM states
package res_reader_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int TOTAL_ADDR_DEF = 128;
  localparam int FIFO_DEPTH     = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
endpackage

// File: rtl/res_rd_fifo.sv
// res_rd_fifo: 4-entry FIFO buffering words returned by the result memory.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   push, push_data    : write side; push while full is accepted only with a pop
//   pop, pop_data      : read side; pop_data is the current head (first-word fall-through)
//   empty, count       : status; count is occupancy 0..4
module res_rd_fifo
  import res_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic [2:0]            count
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  full, do_push, do_pop;

  assign empty    = (count == 3'd0);
  assign full     = (count == 3'(FIFO_DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b0, do_push} - {2'b0, do_pop};
    end
  end
endmodule

// File: rtl/res_reader.sv
// res_reader: streams a block of words out of a 2-cycle-latency result memory.
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   start, start_addr, num_words : readout request (num_words==0 means whole memory)
//   busy, done                : status; done pulses once after the final handshake
//   mem_addr, mem_wren, mem_q : result memory port (read only)
//   out_data, out_valid, out_ready, out_last : valid/ready output stream
module res_reader
  import res_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TOTAL_ADDR = TOTAL_ADDR_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam logic [ADDR_WIDTH:0]   FULL_LEN  = (ADDR_WIDTH+1)'(TOTAL_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_ADDR - 1);

  state_t              state;
  logic [ADDR_WIDTH:0] iss_rem, out_rem, req_len;
  logic [1:0]          vld_pipe;   // tracks reads in flight through the memory latency
  logic [2:0]          fifo_count, credit_used;
  logic                fifo_empty, issue, fire;

  assign mem_wren = 1'b0;
  assign req_len  = (num_words == '0) ? FULL_LEN : num_words;

  // Reserve a FIFO slot for every read in flight so a stalled consumer never
  // causes an overflow.
  assign credit_used = fifo_count + {2'b0, vld_pipe[0]} + {2'b0, vld_pipe[1]};
  assign issue       = (state == S_READ) && (credit_used < 3'(FIFO_DEPTH));
  assign out_valid   = !fifo_empty;
  assign fire        = out_valid && out_ready;
  assign out_last    = out_valid && (out_rem == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      iss_rem  <= '0;
      out_rem  <= '0;
      vld_pipe <= '0;
    end else begin
      done     <= 1'b0;
      vld_pipe <= {vld_pipe[0], issue};
      if (issue) begin
        mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
        iss_rem  <= iss_rem - 1'b1;
      end
      if (fire) out_rem <= out_rem - 1'b1;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_READ;
          busy     <= 1'b1;
          mem_addr <= start_addr;
          iss_rem  <= req_len;
          out_rem  <= req_len;
        end
        S_READ: if (issue && iss_rem == (ADDR_WIDTH+1)'(1)) state <= S_DRAIN;
        S_DRAIN: if (fire && out_rem == (ADDR_WIDTH+1)'(1)) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  res_rd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vld_pipe[1]),
    .push_data (mem_q),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule
